// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-add multiplier with start/done handshake.
// One partial product per clock; signed (MULT) or unsigned (MULTU) per operation.
// Optional macro EARLY_TERM_EN: stop iterating once no multiplier bits remain.
module seq_multiplier #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   dataA,
    input  logic [WIDTH-1:0]   dataB,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] dataOut
);

    localparam int unsigned CW = $clog2(WIDTH);

    // S_FIN separates the final accumulate from the sign fix-up and write-back,
    // giving one edge between the last iteration and the done pulse.
    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIN,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplr_q, mplr_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   out_q, out_d;

    logic [WIDTH-1:0]     mag_a, mag_b;
    logic                 last_iter;

    // Operand magnitudes; the most negative value maps to 2^(W-1) as unsigned
    always_comb begin
        mag_a = (is_signed && dataA[WIDTH-1]) ? -dataA : dataA;
        mag_b = (is_signed && dataB[WIDTH-1]) ? -dataB : dataB;
    end

    // Final-iteration detection
    always_comb begin
`ifdef EARLY_TERM_EN
        last_iter = (cnt_q == CW'(WIDTH - 1)) || ((mplr_q >> 1) == '0);
`else
        last_iter = (cnt_q == CW'(WIDTH - 1));
`endif
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        out_d   = out_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    mcand_d = {{WIDTH{1'b0}}, mag_a};
                    mplr_d  = mag_b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    // A zero operand must never yield a negated result
                    neg_d   = is_signed & (dataA[WIDTH-1] ^ dataB[WIDTH-1])
                              & (dataA != '0) & (dataB != '0);
                    state_d = S_CALC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (mplr_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (last_iter) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                out_d   = neg_q ? -acc_q : acc_q;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            out_q   <= out_d;
        end
    end

    assign busy    = (state_q == S_CALC) || (state_q == S_FIN);
    assign done    = (state_q == S_DONE);
    assign dataOut = out_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed and random checks of seq_multiplier (WIDTH=32)
// against an arithmetic reference model; honours EARLY_TERM_EN for latency.
module tb_seq_multiplier;

    localparam int unsigned W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          is_signed;
    logic [W-1:0]  dataA;
    logic [W-1:0]  dataB;
    logic          busy;
    logic          done;
    logic [2*W-1:0] dataOut;

    int n_assert = 0;
    int n_fail   = 0;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .dataA     (dataA),
        .dataB     (dataB),
        .busy      (busy),
        .done      (done),
        .dataOut   (dataOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference product from plain integer arithmetic
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb;
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            return sa * sb;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    // Edges from the start edge to the edge that raises done
    function automatic int latency(input logic [31:0] b, input logic s);
`ifdef EARLY_TERM_EN
        logic [31:0] mag;
        int hi;
        mag = (s && b[31]) ? -b : b;
        hi = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) hi = i + 1;
        return ((hi == 0) ? 1 : hi) + 1;
`else
        return int'(W) + 1;
`endif
    endfunction

    // Present operands with start for one edge (edge 0), then scramble inputs
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        start = 1'b1; dataA = a; dataB = b; is_signed = s;
        @(posedge clk); #1;
        start = 1'b0; dataA = $urandom; dataB = $urandom; is_signed = 1'($urandom);
    endtask

    // Wait (bounded) for done; check latency, product, busy; optional start pulse mid-op
    task automatic await(input string tag, input logic [63:0] exp, input int lat, input bit disturb);
        int edges;
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
            if (edges == 1) check({tag, "_busy"}, 64'(busy), 64'd1);
            if (disturb && edges == 2) begin
                start = 1'b1; dataA = $urandom; dataB = $urandom; is_signed = 1'($urandom);
            end
            if (disturb && edges == 3) start = 1'b0;
        end while (!done && edges < lat + 5);
        check({tag, "_lat"}, 64'(edges), 64'(lat));
        check({tag, "_prod"}, dataOut, exp);
        check({tag, "_busy_done"}, 64'(busy), 64'd0);
    endtask

    task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s);
        issue(a, b, s);
        await(tag, model(a, b, s), latency(b, s), 1'b0);
    endtask

    initial begin
        logic [31:0] a, b;
        logic s;
        reset = 1'b0; start = 1'b0; is_signed = 1'b0; dataA = '0; dataB = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", dataOut, 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_done", 64'(done), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);

        // Full-range and signed directed cases
        op("umax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("umax_lit", dataOut, 64'hFFFF_FFFE_0000_0001);
        @(posedge clk); #1;
        check("done_pulse", 64'(done), 64'd0);
        check("hold", dataOut, 64'hFFFF_FFFE_0000_0001);
        op("neg7x6", 32'hFFFF_FFF9, 32'd6, 1'b1);
        check("neg7x6_lit", dataOut, 64'hFFFF_FFFF_FFFF_FFD6);
        op("minsq", 32'h8000_0000, 32'h8000_0000, 1'b1);
        check("minsq_lit", dataOut, 64'h4000_0000_0000_0000);
        op("zero_neg", 32'd0, 32'hFFFF_FFFB, 1'b1);
        check("zero_neg_lit", dataOut, 64'd0);
        op("neg_zero", 32'hFFFF_FFFB, 32'd0, 1'b1);
        op("b_one", 32'h1234_5678, 32'd1, 1'b0);
        op("b_msb", 32'h0000_0003, 32'h8000_0000, 1'b0);
        op("sgn_negneg", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);

        // Start during CALC is ignored
        issue(32'd3, 32'h0001_2345, 1'b0);
        await("ignore", 64'd3 * 64'h0001_2345, latency(32'h0001_2345, 1'b0), 1'b1);

        // Back-to-back: start asserted in the done cycle
        issue(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1);
        await("b2b_1", model(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1), latency(32'hCAFE_F00D, 1'b1), 1'b0);
        issue(32'h0000_00FF, 32'hFFFF_FF00, 1'b1);
        await("b2b_2", model(32'h0000_00FF, 32'hFFFF_FF00, 1'b1), latency(32'hFFFF_FF00, 1'b1), 1'b0);

        // Reset mid-operation
        issue(32'h7654_3210, 32'h8765_4321, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_out", dataOut, 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check("midrst_nodone", 64'(done), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        op("after_rst", 32'h0BAD_F00D, 32'h0000_1001, 1'b0);

        // Random sweep, both modes, varying multiplier magnitude
        for (int i = 0; i < 300; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            s = 1'($urandom);
            if ($urandom_range(0, 15) == 0) a = '0;
            if (s && $urandom_range(0, 1) == 1) b = -b;
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
            op("rand", a, b, s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
